// File: rtl/kacc_pkg.sv
// Shared constants, FSM state type and FP16 field layout for the Kulisch-to-FP16 read-out path.
// Optional status flags are enabled in kulisch_to_fp16 by defining KACC2FP_FLAGS_EN.
package kacc_pkg;

    localparam int unsigned DWIDTH    = 16;
    localparam int unsigned EWIDTH    = 5;
    localparam int unsigned MWIDTH    = 10;
    localparam int unsigned BIAS      = 15;
    localparam int unsigned WWIDTH    = 79;
    localparam int unsigned FRAC_BITS = 48;
    localparam int unsigned CHUNK     = 8;

    localparam int unsigned NCHUNK    = (WWIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PWIDTH    = NCHUNK * CHUNK;
    localparam int unsigned PBITS     = $clog2(PWIDTH);
    localparam int unsigned IBITS     = $clog2(CHUNK);
    // Subnormal quantum is 2^-24, i.e. this many accumulator LSBs.
    localparam int unsigned SUB_SHIFT = FRAC_BITS - 24;

    localparam logic [DWIDTH-1:0] FP16_POS_INF = 16'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NORM,
        ROUND,
        DONE
    } kacc2fp_state_t;

    typedef struct packed {
        logic              sign;
        logic [EWIDTH-1:0] expo;
        logic [MWIDTH-1:0] mant;
    } fp16_t;

    function automatic fp16_t fp16_inf(input logic sign);
        fp16_t r;
        r      = FP16_POS_INF;
        r.sign = sign;
        return r;
    endfunction

endpackage

// File: rtl/kacc_lzc_chunk.sv
// Combinational leading-one encoder over one scan chunk: nz_o flags a set bit,
// idx_o is the bit position of the most significant one.
module kacc_lzc_chunk #(
    parameter int unsigned Width = 8,
    localparam int unsigned IdxW = $clog2(Width)
) (
    input  logic [Width-1:0] chunk_i,
    output logic             nz_o,
    output logic [IdxW-1:0]  idx_o
);

    always_comb begin
        nz_o  = |chunk_i;
        idx_o = '0;
        // Ascending scan so the highest set bit wins.
        for (int i = 0; i < Width; i++) begin
            if (chunk_i[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/kulisch_to_fp16.sv
// Converts a two's-complement Kulisch accumulator word to FP16 with round-to-nearest-even:
// chunked leading-one scan, normalise, round. Define KACC2FP_FLAGS_EN for status flag outputs.
module kulisch_to_fp16
    import kacc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc_valid,
    output logic              o_acc_ready,
    input  logic [WWIDTH-1:0] i_kulisch_acc,
    output logic              o_fp_valid,
    input  logic              i_fp_ready,
    output logic [DWIDTH-1:0] o_fp_data
`ifdef KACC2FP_FLAGS_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_inexact
`endif
);

    localparam logic [PBITS-1:0] BASE_TOP = PBITS'((NCHUNK - 1) * CHUNK);
    localparam logic signed [7:0] EOFF    = 8'(FRAC_BITS - BIAS);
    localparam logic signed [7:0] EMAX    = 8'((1 << EWIDTH) - 1);

    kacc2fp_state_t state_q, state_d;

    logic               sign_q, sign_d;
    logic [WWIDTH-1:0]  mag_q, mag_d;
    logic [PBITS-1:0]   base_q, base_d;
    logic [PBITS-1:0]   p_q, p_d;
    logic               zero_q, zero_d;
    logic signed [7:0]  e_q, e_d;
    logic [MWIDTH-1:0]  man_q, man_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               sub_q, sub_d;
    fp16_t              fp_q, fp_d;

    // Scan datapath: base_q is the LSB position of the chunk under test.
    logic [PWIDTH-1:0]  padded;
    logic [CHUNK-1:0]   chunk;
    logic               lzc_nz;
    logic [IBITS-1:0]   lzc_idx;

    assign padded = PWIDTH'(mag_q);
    assign chunk  = CHUNK'(padded >> base_q);

    kacc_lzc_chunk #(
        .Width (CHUNK)
    ) u_lzc (
        .chunk_i (chunk),
        .nz_o    (lzc_nz),
        .idx_o   (lzc_idx)
    );

    // Normalise datapath.
    logic signed [7:0]  e_norm;
    logic [WWIDTH-1:0]  norm_shifted;
    logic               sub_sticky;

    always_comb begin
        e_norm       = $signed({1'b0, p_q}) - EOFF;
        norm_shifted = mag_q << (PBITS'(WWIDTH - 1) - p_q);
        sub_sticky   = |(mag_q << (WWIDTH - SUB_SHIFT + 1));
    end

    // Round datapath.
    logic               round_up;
    logic [MWIDTH:0]    man_sum;
    logic signed [7:0]  e_rnd;
    logic [DWIDTH-2:0]  sub_sum;
    fp16_t              round_res;

    always_comb begin
        round_up = guard_q & (sticky_q | man_q[0]);
        man_sum  = {1'b0, man_q} + (MWIDTH + 1)'(round_up);
        e_rnd    = e_q + (man_sum[MWIDTH] ? 8'sd1 : 8'sd0);
        // Carry out of a subnormal mantissa lands in the exponent LSB: smallest normal.
        sub_sum  = {{EWIDTH{1'b0}}, man_q} + (DWIDTH - 1)'(round_up);
        if (zero_q) begin
            round_res = '0;
        end else if (sub_q) begin
            round_res = {sign_q, sub_sum};
        end else if (e_rnd >= EMAX) begin
            round_res = fp16_inf(sign_q);
        end else begin
            round_res = {sign_q, e_rnd[EWIDTH-1:0], man_sum[MWIDTH-1:0]};
        end
    end

    assign o_acc_ready = (state_q == IDLE) && !rst;
    assign o_fp_valid  = (state_q == DONE);
    assign o_fp_data   = fp_q;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        base_d   = base_q;
        p_d      = p_q;
        zero_d   = zero_q;
        e_d      = e_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        sub_d    = sub_q;
        fp_d     = fp_q;

        unique case (state_q)
            IDLE: begin
                if (i_acc_valid && o_acc_ready) begin
                    sign_d  = i_kulisch_acc[WWIDTH-1];
                    mag_d   = i_kulisch_acc[WWIDTH-1] ? (~i_kulisch_acc + WWIDTH'(1))
                                                      : i_kulisch_acc;
                    base_d  = BASE_TOP;
                    zero_d  = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (lzc_nz) begin
                    p_d     = base_q + PBITS'(lzc_idx);
                    state_d = NORM;
                end else if (base_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = NORM;
                end else begin
                    base_d  = base_q - PBITS'(CHUNK);
                end
            end
            NORM: begin
                e_d = e_norm;
                if (zero_q) begin
                    man_d    = '0;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    sub_d    = 1'b0;
                end else if (e_norm >= 8'sd1) begin
                    man_d    = norm_shifted[WWIDTH-2 -: MWIDTH];
                    guard_d  = norm_shifted[WWIDTH-2-MWIDTH];
                    sticky_d = |norm_shifted[WWIDTH-3-MWIDTH:0];
                    sub_d    = 1'b0;
                end else begin
                    man_d    = MWIDTH'(mag_q >> SUB_SHIFT);
                    guard_d  = mag_q[SUB_SHIFT-1];
                    sticky_d = sub_sticky;
                    sub_d    = 1'b1;
                end
                state_d = ROUND;
            end
            ROUND: begin
                fp_d    = round_res;
                state_d = DONE;
            end
            DONE: begin
                if (i_fp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            base_q   <= BASE_TOP;
            p_q      <= '0;
            zero_q   <= 1'b0;
            e_q      <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            sub_q    <= 1'b0;
            fp_q     <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            base_q   <= base_d;
            p_q      <= p_d;
            zero_q   <= zero_d;
            e_q      <= e_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            sub_q    <= sub_d;
            fp_q     <= fp_d;
        end
    end

`ifdef KACC2FP_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic inx_q, inx_d;
    logic inx_now;

    always_comb begin
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        inx_now = guard_q | sticky_q;
        if (state_q == ROUND) begin
            ovf_d = (round_res.expo == '1);
            unf_d = (round_res.expo == '0) && inx_now;
            inx_d = inx_now;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inx_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            inx_q <= inx_d;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_inexact   = inx_q;
`endif

endmodule
